// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared types and helpers for the IIR filter back-end
//               (sample type, default width, decimation log2 helper).
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

   // Default sample width, matching the IIR filter output.
   localparam int DATA_W_DEF = 8;

   // One filter output sample.
   typedef logic signed [DATA_W_DEF-1:0] sample_t;

   // log2 of a power-of-two decimation ratio (ceil for non powers of two).
   function automatic int decim_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/iir_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iir_sync_fifo
// Description : Synchronous FIFO with wrap-bit pointers, occupancy output and
//               simultaneous read/write (also when full). Head is shown as
//               zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear_i,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_wr;
   logic             do_rd;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o   = wr_ptr_q - rd_ptr_q;
   // A write into a full FIFO is legal when the head leaves in the same cycle.
   assign do_rd     = rd_en_i && !empty_o;
   assign do_wr     = wr_en_i && (!full_o || do_rd);
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Pointer update; clear empties the FIFO and overrides any access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage array write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_wr && !clear_i) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/iir_decimator.sv
`default_nettype none
// ============================================================================
// Module      : iir_decimator
// Description : Boxcar-average-and-decimate stage after the IIR filter.
//               Sums DECIM valid samples, floors the mean with an arithmetic
//               shift and buffers results toward a ready/valid consumer.
//               Sticky overflow flags results lost to consumer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_decimator
   import iir_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic signed [DATA_W-1:0]      in_data,
   input  logic                          flush,
   output logic                          out_valid,
   output logic signed [DATA_W-1:0]      out_data,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int                D_LOG2  = decim_log2(DECIM);
   localparam int                ACC_W   = DATA_W + D_LOG2;
   localparam logic [D_LOG2-1:0] PH_LAST = D_LOG2'(DECIM - 1);

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [ACC_W-1:0]  sum;
   logic [D_LOG2-1:0]        phase_q, phase_d;
   logic                     overflow_q, overflow_d;
   logic signed [DATA_W-1:0] result;
   logic                     push;
   logic                     pop;
   logic                     fifo_empty;
   logic                     fifo_full;

   // Accumulator is wide enough for DECIM full-scale samples, so no saturation.
   assign sum    = acc_q + ACC_W'(in_data);
   assign result = DATA_W'(sum >>> D_LOG2);
   assign pop    = out_valid && out_ready && !flush;

   // Next-state for accumulator/phase and the block-complete push strobe.
   always_comb begin
      acc_d      = acc_q;
      phase_d    = phase_q;
      push       = 1'b0;
      overflow_d = overflow_q;
      if (flush) begin
         acc_d   = '0;
         phase_d = '0;
      end else if (in_valid) begin
         if (phase_q == PH_LAST) begin
            acc_d   = '0;
            phase_d = '0;
            push    = 1'b1;
         end else begin
            acc_d   = sum;
            phase_d = phase_q + 1'b1;
         end
      end
      if (push && fifo_full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   // State registers; a reset mid-block drops the partial sum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q      <= '0;
         phase_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         phase_q    <= phase_d;
         overflow_q <= overflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign out_valid = !fifo_empty;

   iir_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (flush),
      .wr_en_i   (push),
      .wr_data_i (result),
      .rd_en_i   (pop),
      .rd_data_o (out_data),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full),
      .level_o   (fifo_level)
   );

endmodule
`default_nettype wire
